// File: rtl/axi_4_wrapper.sv
`default_nettype none
// ============================================================================
// Module   : axi_4_wrapper
// Purpose  : AXI4 burst self-test. Master FSM writes PATTERN+i into an internal
//            AXI4 slave memory, reads it back and checks it.
//            Optional macro AXI4_WRAPPER_LOOP_EN repeats passes, seed PATTERN+n.
// Revision : 1.0  initial release
// ============================================================================
module axi_4_wrapper #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          BURST_LEN = 16,
   parameter logic [31:0] PATTERN   = 32'hA5A5_0000,
   parameter int          MEM_DEPTH = 256
) (
   input  logic        aclk,
   input  logic        aresetn,
   output logic        done,
   output logic        error,
   output logic [15:0] pass_count
);

   localparam int          c_iw    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [31:0] c_depth = 32'(MEM_DEPTH);
   localparam logic [7:0]  c_len   = 8'(BURST_LEN - 1);
   localparam logic [8:0]  c_last  = 9'(BURST_LEN - 1);
   localparam logic [2:0]  c_size  = 3'b010;
   localparam logic [1:0]  c_incr  = 2'b01;
   localparam logic [1:0]  c_okay  = 2'b00;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_ADDR = 3'd1,
      WR_DATA = 3'd2,
      WR_RESP = 3'd3,
      RD_ADDR = 3'd4,
      RD_DATA = 3'd5,
      CHECK   = 3'd6,
      DONE    = 3'd7
   } state_t;

   state_t r_state;

   // Internal AXI4 bus
   logic [31:0] w_awaddr, w_araddr;
   logic [7:0]  w_awlen, w_arlen;
   logic [2:0]  w_awsize, w_arsize;
   logic [1:0]  w_awburst, w_arburst;
   logic [3:0]  w_wstrb;
   logic [1:0]  w_bresp, w_rresp;
   logic        r_awvalid, r_awready;
   logic        r_wvalid, r_wready, r_wlast;
   logic [31:0] r_wdata;
   logic        r_bvalid, r_bready;
   logic        r_arvalid, r_arready;
   logic        r_rvalid, r_rready, r_rlast;
   logic [31:0] r_rdata;

   logic [8:0]  r_beat;
   logic [31:0] r_seed;

   logic [31:0]     r_mem [MEM_DEPTH];
   logic [c_iw-1:0] r_waddr, r_raddr;
   logic [7:0]      r_wcnt, r_wlen, r_rcnt, r_rlen;
   logic            r_winc, r_rinc;

   assign w_awaddr  = BASE_ADDR;
   assign w_araddr  = BASE_ADDR;
   assign w_awlen   = c_len;
   assign w_arlen   = c_len;
   assign w_awsize  = c_size;
   assign w_arsize  = c_size;
   assign w_awburst = c_incr;
   assign w_arburst = c_incr;
   assign w_wstrb   = 4'hF;
   assign w_bresp   = c_okay;
   assign w_rresp   = c_okay;

   function automatic logic [c_iw-1:0] f_word(input logic [31:0] a);
      return c_iw'((a >> 2) % c_depth);
   endfunction

   function automatic logic [c_iw-1:0] f_next(input logic [c_iw-1:0] i);
      return (i == c_iw'(MEM_DEPTH - 1)) ? '0 : i + 1'b1;
   endfunction

   // Master FSM; every bus output is registered
   always_ff @(posedge aclk or posedge aresetn) begin
      if (aresetn) begin
         r_state    <= IDLE;
         r_awvalid  <= 1'b0;
         r_wvalid   <= 1'b0;
         r_wdata    <= '0;
         r_wlast    <= 1'b0;
         r_bready   <= 1'b0;
         r_arvalid  <= 1'b0;
         r_rready   <= 1'b0;
         r_beat     <= '0;
         r_seed     <= PATTERN;
         done       <= 1'b0;
         error      <= 1'b0;
         pass_count <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_awvalid <= 1'b1;
               r_state   <= WR_ADDR;
            end
            WR_ADDR: if (r_awvalid && r_awready) begin
               r_awvalid <= 1'b0;
               r_wvalid  <= 1'b1;
               r_wdata   <= r_seed;
               r_wlast   <= (c_last == 9'd0);
               r_beat    <= '0;
               r_state   <= WR_DATA;
            end
            WR_DATA: if (r_wvalid && r_wready) begin
               if (r_wlast) begin
                  r_wvalid <= 1'b0;
                  r_wlast  <= 1'b0;
                  r_bready <= 1'b1;
                  r_state  <= WR_RESP;
               end else begin
                  r_beat  <= r_beat + 9'd1;
                  r_wdata <= r_wdata + 32'd1;
                  r_wlast <= (r_beat + 9'd1 == c_last);
               end
            end
            WR_RESP: if (r_bvalid && r_bready) begin
               if (w_bresp != c_okay) error <= 1'b1;
               r_bready  <= 1'b0;
               r_arvalid <= 1'b1;
               r_state   <= RD_ADDR;
            end
            RD_ADDR: if (r_arvalid && r_arready) begin
               r_arvalid <= 1'b0;
               r_rready  <= 1'b1;
               r_beat    <= '0;
               r_state   <= RD_DATA;
            end
            RD_DATA: if (r_rvalid && r_rready) begin
               if (r_rdata != r_seed + 32'(r_beat) || w_rresp != c_okay) error <= 1'b1;
               r_beat <= r_beat + 9'd1;
               if (r_rlast) begin
                  r_rready <= 1'b0;
                  r_state  <= CHECK;
               end
            end
            CHECK: begin
               if (pass_count != 16'hFFFF) pass_count <= pass_count + 16'd1;
               done    <= 1'b1;
               r_state <= DONE;
            end
            DONE: begin
`ifdef AXI4_WRAPPER_LOOP_EN
               r_seed    <= r_seed + 32'd1;
               r_awvalid <= 1'b1;
               r_state   <= WR_ADDR;
`endif
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Slave control: one-cycle AW/AR ready, back-to-back W and R beats
   always_ff @(posedge aclk or posedge aresetn) begin
      if (aresetn) begin
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
         r_rlast   <= 1'b0;
         r_waddr   <= '0;
         r_raddr   <= '0;
         r_wcnt    <= '0;
         r_wlen    <= '0;
         r_rcnt    <= '0;
         r_rlen    <= '0;
         r_winc    <= 1'b0;
         r_rinc    <= 1'b0;
      end else begin
         r_awready <= r_awvalid && !r_awready;
         r_arready <= r_arvalid && !r_arready;

         if (r_awvalid && r_awready) begin
            r_waddr  <= f_word(w_awaddr);
            r_wlen   <= w_awlen;
            r_wcnt   <= '0;
            r_winc   <= (w_awburst == c_incr) && (w_awsize == c_size);
            r_wready <= 1'b1;
         end else if (r_wvalid && r_wready) begin
            if (r_winc) r_waddr <= f_next(r_waddr);
            r_wcnt <= r_wcnt + 8'd1;
            if (r_wlast || r_wcnt == r_wlen) begin
               r_wready <= 1'b0;
               r_bvalid <= 1'b1;
            end
         end

         if (r_bvalid && r_bready) r_bvalid <= 1'b0;

         if (r_arvalid && r_arready) begin
            r_rvalid <= 1'b1;
            r_rdata  <= r_mem[f_word(w_araddr)];
            r_rlast  <= (w_arlen == 8'd0);
            r_rlen   <= w_arlen;
            r_rcnt   <= '0;
            r_rinc   <= (w_arburst == c_incr) && (w_arsize == c_size);
            r_raddr  <= ((w_arburst == c_incr) && (w_arsize == c_size)) ?
                        f_next(f_word(w_araddr)) : f_word(w_araddr);
         end else if (r_rvalid && r_rready) begin
            if (r_rlast) begin
               r_rvalid <= 1'b0;
               r_rlast  <= 1'b0;
            end else begin
               r_rdata <= r_mem[r_raddr];
               if (r_rinc) r_raddr <= f_next(r_raddr);
               r_rcnt  <= r_rcnt + 8'd1;
               r_rlast <= (r_rcnt + 8'd1 == r_rlen);
            end
         end
      end
   end

   // Memory array is deliberately not reset
   always_ff @(posedge aclk) begin
      if (r_wvalid && r_wready) begin
         for (int b = 0; b < 4; b++) begin
            if (w_wstrb[b]) r_mem[r_waddr][8*b +: 8] <= r_wdata[8*b +: 8];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axi_4_wrapper.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_4_wrapper
// Purpose  : Self-checking bench for axi_4_wrapper against a burst-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_axi_4_wrapper;

   localparam int          BL        = 16;
   localparam logic [31:0] PAT       = 32'hA5A5_0000;
   localparam logic [31:0] WRAP_BASE = 32'h0000_03F0;
   localparam int          DEPTH     = 256;
   localparam int          LAT_MAX   = 3 * BL + 10;

   logic        clk   = 1'b0;
   logic        rst_a = 1'b1;
   logic        rst_w = 1'b1;
   logic        done_a, error_a, done_w, error_w;
   logic [15:0] pc_a, pc_w;

   int n_cmp = 0;
   int n_bad = 0;

   always #4 clk = ~clk;

   axi_4_wrapper u_dut (
      .aclk(clk), .aresetn(rst_a), .done(done_a), .error(error_a), .pass_count(pc_a)
   );

   axi_4_wrapper #(.BASE_ADDR(WRAP_BASE), .MEM_DEPTH(DEPTH)) u_wrap (
      .aclk(clk), .aresetn(rst_w), .done(done_w), .error(error_w), .pass_count(pc_w)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Model: word index of beat i for a burst starting at byte address base
   function automatic int exp_word(input logic [31:0] base, input int i);
      return int'(((base >> 2) + 32'(i)) % DEPTH);
   endfunction

   // Bus monitor on u_dut: handshake counts, payload vs model, VALID hold rule
   int aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0;
   int w_bad = 0, r_bad = 0, hold_bad = 0;
   logic p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_bv = 0, p_br = 0;
   logic p_arv = 0, p_arr = 0, p_rv = 0, p_rr = 0, p_wl = 0, p_rl = 0;
   logic [31:0] p_wd = '0, p_rd = '0;

   always @(negedge clk) begin
      if (rst_a) begin
         aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0;
         w_bad = 0; r_bad = 0; hold_bad = 0;
         p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_bv = 0; p_br = 0;
         p_arv = 0; p_arr = 0; p_rv = 0; p_rr = 0;
      end else begin
         if (p_awv && !p_awr && !u_dut.r_awvalid) hold_bad++;
         if (p_arv && !p_arr && !u_dut.r_arvalid) hold_bad++;
         if (p_bv && !p_br && !u_dut.r_bvalid) hold_bad++;
         if (p_wv && !p_wr && (!u_dut.r_wvalid || u_dut.r_wdata != p_wd || u_dut.r_wlast != p_wl))
            hold_bad++;
         if (p_rv && !p_rr && (!u_dut.r_rvalid || u_dut.r_rdata != p_rd || u_dut.r_rlast != p_rl))
            hold_bad++;
         if (u_dut.r_awvalid && u_dut.r_awready) begin
            aw_n++;
            if (u_dut.w_awaddr != 32'h0 || u_dut.w_awlen != 8'(BL - 1) ||
                u_dut.w_awsize != 3'b010 || u_dut.w_awburst != 2'b01) w_bad++;
         end
         if (u_dut.r_wvalid && u_dut.r_wready) begin
            if (u_dut.r_wdata != PAT + 32'(w_n) || u_dut.r_wlast != (w_n == BL - 1) ||
                u_dut.w_wstrb != 4'hF) w_bad++;
            w_n++;
         end
         if (u_dut.r_bvalid && u_dut.r_bready) b_n++;
         if (u_dut.r_arvalid && u_dut.r_arready) begin
            ar_n++;
            if (u_dut.w_araddr != 32'h0 || u_dut.w_arlen != 8'(BL - 1) ||
                u_dut.w_arsize != 3'b010 || u_dut.w_arburst != 2'b01) w_bad++;
         end
         if (u_dut.r_rvalid && u_dut.r_rready) begin
            if (u_dut.r_rdata != PAT + 32'(r_n) || u_dut.r_rlast != (r_n == BL - 1)) r_bad++;
            r_n++;
         end
         p_awv = u_dut.r_awvalid; p_awr = u_dut.r_awready;
         p_wv  = u_dut.r_wvalid;  p_wr  = u_dut.r_wready;
         p_wd  = u_dut.r_wdata;   p_wl  = u_dut.r_wlast;
         p_bv  = u_dut.r_bvalid;  p_br  = u_dut.r_bready;
         p_arv = u_dut.r_arvalid; p_arr = u_dut.r_arready;
         p_rv  = u_dut.r_rvalid;  p_rr  = u_dut.r_rready;
         p_rd  = u_dut.r_rdata;   p_rl  = u_dut.r_rlast;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [9:0] hs_vec();
      return {u_dut.r_awvalid, u_dut.r_wvalid, u_dut.r_bready, u_dut.r_arvalid, u_dut.r_rready,
              u_dut.r_awready, u_dut.r_wready, u_dut.r_bvalid, u_dut.r_arready, u_dut.r_rvalid};
   endfunction

   task automatic check_in_reset();
      check("rst_done", done_a, 0);
      check("rst_error", error_a, 0);
      check("rst_pass_count", pc_a, 0);
      check("rst_handshake", hs_vec(), 0);
   endtask

   task automatic reset_dut(input int cycles);
      rst_a = 1'b1;
      repeat (cycles) tick();
      check_in_reset();
      rst_a = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!done_a && cyc < 300) begin
         tick();
         cyc++;
      end
   endtask

   task automatic check_clean();
      int cyc;
      wait_done(cyc);
      check("done", done_a, 1);
      check("latency_ok", cyc <= LAT_MAX, 1);
      repeat (10) tick();
      check("error", error_a, 0);
`ifdef AXI4_WRAPPER_LOOP_EN
      check("pass_count_ge1", pc_a >= 16'd1, 1);
`else
      check("pass_count", pc_a, 1);
      check("aw_count", aw_n, 1);
      check("w_count", w_n, BL);
      check("b_count", b_n, 1);
      check("ar_count", ar_n, 1);
      check("r_count", r_n, BL);
      check("payload_bad", w_bad, 0);
      check("rdata_bad", r_bad, 0);
      check("valid_hold_bad", hold_bad, 0);
      for (int i = 0; i < BL; i++)
         check("mem_word", u_dut.r_mem[exp_word(32'h0, i)], PAT + 32'(i));
`endif
   endtask

   task automatic run_corrupt(input int k, input logic [31:0] mask);
      int cyc;
      reset_dut(2 + $urandom_range(0, 4));
      cyc = 0;
      while (!u_dut.r_bvalid && cyc < 200) begin
         tick();
         cyc++;
      end
      check("bvalid_seen", u_dut.r_bvalid, 1);
      u_dut.r_mem[exp_word(32'h0, k)] = u_dut.r_mem[exp_word(32'h0, k)] ^ mask;
      wait_done(cyc);
      tick();
      check("corrupt_done", done_a, 1);
      check("corrupt_error", error_a, 1);
      check("corrupt_pass_count", pc_a, 1);
      check("corrupt_rdata_bad", r_bad, 1);
   endtask

   task automatic run_abort(input int k);
      int cyc;
      reset_dut(2 + $urandom_range(0, 4));
      cyc = 0;
      while (w_n < k && cyc < 200) begin
         tick();
         cyc++;
      end
      check("abort_reached", w_n >= k, 1);
      rst_a = 1'b1;
      #1;
      check_in_reset();
      reset_dut(1 + $urandom_range(0, 3));
      check_clean();
   endtask

   initial begin
      int kind, k;
      rst_a = 1'b1;
      rst_w = 1'b1;
      #100;
      check_in_reset();
      #50;
      rst_a = 1'b0;
      rst_w = 1'b0;

`ifdef AXI4_WRAPPER_LOOP_EN
      repeat (250) tick();
      check("loop_pass_count_ge3", pc_a >= 16'd3, 1);
      check("loop_error", error_a, 0);
      check("loop_done", done_a, 1);
      check("loop_word0_seed", (u_dut.r_mem[0] == PAT + 32'(pc_a) - 32'd1) ||
                               (u_dut.r_mem[0] == PAT + 32'(pc_a)), 1);
      check("wrap_error", error_w, 0);
      check("wrap_done", done_w, 1);
`else
      check_clean();

      check("wrap_done", done_w, 1);
      check("wrap_error", error_w, 0);
      check("wrap_pass_count", pc_w, 1);
      for (int i = 0; i < BL; i++)
         check("wrap_mem_word", u_wrap.r_mem[exp_word(WRAP_BASE, i)], PAT + 32'(i));

      run_corrupt(3, 32'h0000_0100);
      run_abort(7);

      for (int it = 0; it < 6; it++) begin
         kind = $urandom_range(0, 2);
         k    = $urandom_range(0, BL - 1);
         case (kind)
            0: run_corrupt(k, $urandom | 32'h1);
            1: run_abort(k);
            default: begin
               reset_dut(2 + $urandom_range(0, 4));
               check_clean();
            end
         endcase
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/axi_4_wrapper.md
AXI_4_WRAPPER -- requirements
Module: axi_4_wrapper

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, byte address of the test burst.
REQ-002 Parameter BURST_LEN, default 16, beats per burst (1..256).
REQ-003 Parameter PATTERN, default 32'hA5A5_0000, data seed; beat i carries PATTERN + i.
REQ-004 Parameter MEM_DEPTH, default 256, internal memory depth in 32-bit words.
REQ-005 The port list SHALL contain exactly one clock and one reset: aclk is the clock and aresetn is the reset; aresetn SHALL be asynchronous and active-high (1 = in reset).
REQ-006 aclk  input  1  clock, all logic on rising edge; nominal 125 MHz (8 ns period).
REQ-007 aresetn  input  1  asynchronous active-high reset.
REQ-008 done  output  1  sticky; test sequence completed.
REQ-009 error  output  1  sticky; data mismatch or non-OKAY response seen.
REQ-010 pass_count  output  16  completed passes, saturating at 16'hFFFF.

Function
REQ-011 The block SHALL contain an AXI4 master FSM and an AXI4 slave memory (MEM_DEPTH x 32, OKAY responses only) connected internally by a 32-bit data, 32-bit address AXI4 bus.
REQ-012 FSM states IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, CHECK, DONE; IDLE -> WR_ADDR one cycle after reset release.
REQ-013 WR_ADDR: AWVALID=1, AWADDR=BASE_ADDR, AWLEN=BURST_LEN-1, AWSIZE=3'b010, AWBURST=INCR; -> WR_DATA on AWVALID&AWREADY.
REQ-014 WR_DATA: WVALID=1, WDATA=PATTERN+i, WSTRB=4'hF, WLAST on beat BURST_LEN-1; i advances only on WVALID&WREADY; -> WR_RESP after last beat.
REQ-015 WR_RESP: BREADY=1; on BVALID, BRESP != OKAY sets error; -> RD_ADDR.
REQ-016 RD_ADDR: ARVALID=1 with same address/len/size/burst as write; -> RD_DATA on ARVALID&ARREADY.
REQ-017 RD_DATA: RREADY=1; each RVALID beat compared to PATTERN+i; mismatch or RRESP != OKAY sets error; RLAST on beat BURST_LEN-1 -> CHECK.
REQ-018 CHECK: pass_count increments by 1 (saturating); -> DONE; done=1 one cycle later.
REQ-019 Any VALID, once asserted, SHALL stay high with stable payload until its READY; master never deasserts BREADY/RREADY mid-burst.
REQ-020 Slave SHALL accept AW/AR with one-cycle READY, accept write beats back-to-back (WREADY=1 during data phase), return BVALID the cycle after WLAST, and return read beats back-to-back with RLAST on the final beat.
REQ-021 Slave address = (addr >> 2) mod MEM_DEPTH (wrap-around); INCR beats increment by 4 bytes.
REQ-022 Nominal single pass SHALL complete within 3*BURST_LEN+10 cycles of reset release.

Reset
REQ-023 While aresetn=1: FSM = IDLE, all master VALIDs/READYs = 0, done=0, error=0, pass_count=0, slave VALIDs/READYs = 0; memory contents undefined and not cleared.
REQ-024 Reset asserted mid-burst SHALL abort immediately; after release the sequence restarts from IDLE with no residual handshake state.

Configuration
REQ-025 Macro AXI4_WRAPPER_LOOP_EN: when defined, DONE returns to WR_ADDR on the next cycle and the seed for pass n is PATTERN+n (done stays high after first pass, error sticky); when undefined, FSM remains in DONE until reset.

Verification
REQ-026 Reset 150 ns, 8 ns clock, defaults -> done=1, error=0, pass_count=1 within 60 cycles; memory words 0..15 = A5A5_0000..A5A5_000F.
REQ-027 Observe bus -> exactly 1 AW, 16 W beats with WLAST only on 16th, 1 B, 1 AR, 16 R beats; no VALID drop before READY.
REQ-028 Hierarchically corrupt memory word 3 after BVALID, before RD_ADDR -> error=1, done=1.
REQ-029 Assert aresetn during WR_DATA beat 7, release -> outputs zero during reset, then clean pass: done=1, error=0, pass_count=1.
REQ-030 AXI4_WRAPPER_LOOP_EN defined, run 2000 ns -> pass_count >= 3, error=0, memory word 0 = PATTERN + (pass_count-1).
REQ-031 BASE_ADDR=32'h0000_03F0, MEM_DEPTH=256 -> beats wrap to words 252..255 then 0..11; done=1, error=0.
